// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store controller in front of a
// 1024x32 byte-enabled data RAM.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only in IDLE, rst low)
//   req_we                 1 = store, 0 = load
//   req_size               00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned           zero-extend loads when 1
//   req_addr               byte address
//   req_wdata              right-aligned store data
//   rsp_valid/rsp_ready    response handshake, held until accepted
//   rsp_rdata              extended load data, 0 for stores
//   rsp_err                misaligned / reserved-size request
//   mem_addr               RAM word address
//   mem_sel                RAM byte select
//   mem_we, mem_ld         RAM write / load enable (ACCESS only)
//   mem_wdata              lane-replicated store data
//   mem_rdata              combinational RAM read data
//
// Configuration macro: MAU_ERR_TRAP_EN
//   defined   : misaligned or size-11 requests leave the RAM untouched and
//               respond with rsp_err=1, rsp_rdata=0
//   undefined : rsp_err is 0, addresses are force-aligned, size 11 acts as word
module mem_access_unit #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_sel,
  output logic              mem_we,
  output logic              mem_ld,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WA_W = ADDR_W - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err_c;
  logic [1:0]        off_c;
  logic [3:0]        sel_c;
  logic [DATA_W-1:0] wrep_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [DATA_W-1:0] ld_c;
  logic              access_c;

  // Request error classification on the registered fields.
  always_comb begin
    req_err_c = 1'b0;
`ifdef MAU_ERR_TRAP_EN
    unique case (size_q)
      SZ_BYTE: req_err_c = 1'b0;
      SZ_HALF: req_err_c = addr_q[0];
      SZ_WORD: req_err_c = (addr_q[1:0] != 2'b00);
      default: req_err_c = 1'b1;
    endcase
`endif
  end

  // Lane offset, byte select and replicated store data. Half and word
  // offsets are force-aligned; when trapping, an erroring request never
  // reaches the RAM so the aligned values are harmless.
  always_comb begin
    off_c  = 2'b00;
    sel_c  = 4'b1111;
    wrep_c = wdata_q;
    unique case (size_q)
      SZ_BYTE: begin
        off_c  = addr_q[1:0];
        sel_c  = 4'b0001 << addr_q[1:0];
        wrep_c = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        off_c  = {addr_q[1], 1'b0};
        sel_c  = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep_c = {2{wdata_q[15:0]}};
      end
      default: begin
        off_c  = 2'b00;
        sel_c  = 4'b1111;
        wrep_c = wdata_q;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    byte_c = mem_rdata[{off_c, 3'b000} +: 8];
    half_c = mem_rdata[{off_c[1], 4'b0000} +: 16];
    unique case (size_q)
      SZ_BYTE: ld_c = uns_q ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: ld_c = uns_q ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: ld_c = mem_rdata;
    endcase
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_ACCESS;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        err_d   = req_err_c;
        rdata_d = (we_q || req_err_c) ? '0 : ld_c;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request/response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM strobes only in ACCESS; rst gating keeps the RAM quiet during reset.
  assign access_c  = (state_q == S_ACCESS) && !req_err_c;
  assign mem_addr  = addr_q[ADDR_W-1:2];
  assign mem_wdata = wrep_c;
  assign mem_sel   = access_c ? sel_c : 4'b0000;
  assign mem_we    = access_c && we_q && !rst;
  assign mem_ld    = access_c && !we_q && !rst;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  logic unused_c;
  assign unused_c = ^{WA_W[0]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic against a byte-array reference memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_sel;
  logic        mem_we;
  logic        mem_ld;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram     [0:1023];
  logic [7:0]  ref_mem [0:4095];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_sel      (mem_sel),
    .mem_we       (mem_we),
    .mem_ld       (mem_ld),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Byte-enabled RAM with combinational read.
  assign mem_rdata = mem_ld ? ram[mem_addr] : 32'hBAD0_BAD0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_sel);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
  endfunction

  // One complete transaction; called and returns at a falling edge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wd,
                        input int stall, input bit hold,
                        output logic [31:0] got_rd, output logic got_err);
    int          nb, ea, n;
    logic        err;
    logic [31:0] exp_rd, exp_wd, v;
    logic [3:0]  exp_sel;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`ifdef MAU_ERR_TRAP_EN
    err = (size == 2'b11) || ((int'(addr) % nb) != 0);
`else
    err = 1'b0;
`endif
    ea      = int'(addr) - (int'(addr) % nb);
    exp_sel = err ? 4'b0000 : 4'(((1 << nb) - 1) << (ea % 4));
    for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = wd[8*(b % nb) +: 8];
    v = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[ea+i]) << (8*i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
    exp_rd = (we || err) ? 32'h0 : v;

    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
    chk("access_mem_we",  32'(mem_we),  32'(we && !err));
    chk("access_mem_ld",  32'(mem_ld),  32'(!we && !err));
    chk("access_mem_sel", 32'(mem_sel), 32'(exp_sel));
    if (!err) chk("access_mem_addr", 32'(mem_addr), 32'(ea >> 2));
    if (we && !err) chk("access_mem_wdata", mem_wdata, exp_wd);
    chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("access_req_ready", 32'(req_ready), 32'd0);

    @(posedge clk);
    if (we && !err) for (int i = 0; i < nb; i++) ref_mem[ea+i] = wd[8*i +: 8];
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err",   32'(rsp_err), 32'(err));
    chk("resp_mem_we",  32'(mem_we),  32'd0);
    chk("resp_mem_ld",  32'(mem_ld),  32'd0);
    chk("resp_mem_sel", 32'(mem_sel), 32'd0);
    got_rd  = rsp_rdata;
    got_err = rsp_err;

    repeat (stall) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, exp_rd);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("drain_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 12'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_mem_sel",   32'(mem_sel), 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_ld",    32'(mem_ld), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed store/load sequence.
    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 0, 1'b0, rd, er);
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        0, 1'b0, rd, er);
    chk("lw_010", rd, 32'hDEADBEEF);
    do_req(1'b1, 2'b00, 1'b0, 12'h013, 32'h000000A5, 0, 1'b0, rd, er);
    do_req(1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        0, 1'b0, rd, er);
    chk("lb_013", rd, 32'hFFFFFFA5);
    do_req(1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        0, 1'b0, rd, er);
    chk("lbu_013", rd, 32'h000000A5);
    do_req(1'b1, 2'b01, 1'b0, 12'h012, 32'h00008001, 0, 1'b0, rd, er);
    do_req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        0, 1'b0, rd, er);
    chk("lh_012", rd, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 12'h010, 32'h0,        0, 1'b0, rd, er);
    chk("lhu_010", rd, 32'h0000BEEF);

    // Backpressure with the next request already waiting.
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 5, 1'b1, rd, er);
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, 1'b0, rd, er);
    chk("lw_after_bp", rd, 32'h8001BEEF);

    // Misaligned word load.
    do_req(1'b0, 2'b10, 1'b0, 12'h011, 32'h0, 0, 1'b0, rd, er);
`ifdef MAU_ERR_TRAP_EN
    chk("lw_011_rdata", rd, 32'h0);
    chk("lw_011_err", 32'(er), 32'd1);
`else
    chk("lw_011_rdata", rd, 32'h8001BEEF);
    chk("lw_011_err", 32'(er), 32'd0);
`endif

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             12'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 3)), 1'b0, rd, er);
    end

    // Reset during the ACCESS cycle of a word store.
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 12'h020;
    req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rststore_mem_we", 32'(mem_we), 32'd0);
    chk("rststore_mem_ld", 32'(mem_ld), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rststore_ram8",      ram[8], ref_word(8));
    chk("rststore_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rststore_rsp_rdata", rsp_rdata, 32'd0);
    chk("rststore_rsp_err",   32'(rsp_err), 32'd0);
    chk("rststore_mem_sel",   32'(mem_sel), 32'd0);
    chk("rststore_mem_addr",  32'(mem_addr), 32'd0);
    chk("rststore_mem_wdata", mem_wdata, 32'd0);
    chk("rststore_req_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 0, 1'b0, rd, er);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store controller directly upstream of the 1024x32 byte-enabled data RAM.
- Accepts one CPU memory request at a time over a valid/ready handshake, using a byte address and a size code.
- Drives the RAM's word address, byte-select, write-enable, load-enable and lane-replicated write data.
- For loads, extracts the addressed byte or halfword from the RAM's combinational read data, sign- or zero-extends it, and returns it on a registered response handshake.

Parameters:
- ADDR_W, 12, byte-address width; RAM word address is addr[ADDR_W-1:2], so 10 bits at the default.
- DATA_W, 32, data width; fixed at 32, parameterised for documentation only.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE and rst low.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  misaligned or reserved-size request.
- mem_addr  out  10  RAM word address.
- mem_sel  out  4  RAM byte select.
- mem_we  out  1  RAM write enable.
- mem_ld  out  1  RAM load enable.
- mem_wdata  out  32  RAM write data, replicated across lanes.
- mem_rdata  in  32  RAM read data, combinational from mem_addr while mem_ld is high.

Behaviour:
- Reset:
  - Reset is synchronous: state goes to IDLE on the edge where rst is sampled high.
  - After that edge, all outputs are 0, including rsp_valid, rsp_err, rsp_rdata, mem_*.
  - mem_we and mem_ld are additionally gated by !rst combinationally, so no RAM access occurs in any cycle with rst high.
  - A store in progress when rst rises is dropped.
- State machine, three states IDLE, ACCESS, RESP:
  - IDLE to ACCESS when req_valid and req_ready are both high. The request fields are registered on that edge.
  - ACCESS to RESP unconditionally after one cycle. On the exiting edge, rsp_rdata and rsp_err are registered and the RAM store commits.
  - RESP to IDLE when rsp_ready is high. rsp_valid, rsp_rdata and rsp_err are held stable until then.
- Latency: accept at edge N, so rsp_valid is high from edge N+1. Minimum throughput is one request per 3 cycles.
- mem_* outputs:
  - Driven from registered request fields only in ACCESS.
  - Outside ACCESS: mem_we=0, mem_ld=0, mem_sel=0; mem_addr and mem_wdata hold their last value.
- Byte select by size, with off = addr[1:0]:
  - byte: mem_sel = 4'b0001 << off.
  - half: off 0 gives 4'b0011, off 2 gives 4'b1100.
  - word: 4'b1111.
  - mem_sel is only ever one of the 7 legal codes.
- Store data: byte gives {4{wdata[7:0]}}; half gives {2{wdata[15:0]}}; word gives wdata unchanged.
- Load extract:
  - byte: mem_rdata[8*off+:8].
  - half: mem_rdata[16*off[1]+:16].
  - word: full 32 bits.
  - Extension per req_unsigned; the flag is ignored for word.
- Misaligned means half with addr[0]=1, or word with addr[1:0] != 0. Handling is defined under Optional Feature.
- No request is accepted in ACCESS or RESP. req_valid asserted there is ignored and must be held by the source.
- A response is never lost: RESP persists indefinitely while rsp_ready is low.

Optional Feature:
- Macro: MAU_ERR_TRAP_EN.
- Defined:
  - A misaligned or size-11 request still passes through ACCESS and RESP.
  - mem_we, mem_ld and mem_sel stay 0 in ACCESS, so the RAM is untouched.
  - Response is rsp_err=1, rsp_rdata=0.
- Undefined:
  - rsp_err is tied 0.
  - Half clears addr[0] and word clears addr[1:0] before use.
  - Size 11 is treated as word.

Test Plan:
- Word store then load: store addr 0x010, wdata 0xDEADBEEF -> mem_addr=4, mem_sel=1111, mem_we=1 for exactly one cycle. Load addr 0x010 -> rsp_rdata=0xDEADBEEF, rsp_valid at accept+1.
- Byte store and load: after the word store, sb addr 0x013, wdata 0x000000A5 -> mem_sel=1000, mem_wdata=0xA5A5A5A5. lb 0x013 -> 0xFFFFFFA5. lbu 0x013 -> 0x000000A5.
- Half store and load: sh addr 0x012, wdata 0x8001 -> mem_sel=1100. lh 0x012 -> 0xFFFF8001. lhu 0x010 -> 0x0000BEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid stays 1, rsp_rdata stable, req_ready=0 throughout. Next accept occurs the cycle after rsp_ready rises.
- Misaligned lw addr 0x011:
  - With MAU_ERR_TRAP_EN: rsp_err=1, rsp_rdata=0, mem_ld never 1.
  - Without the macro: reads word 4 and rsp_err=0.
- Reset mid-store: assert rst during the ACCESS cycle of sw 0x020 -> mem_we=0 in that cycle, RAM word 8 unchanged, state IDLE, all outputs 0 after the edge.
